uart_bus_master: RTL and testbench
==================================

# uart_bus_master

UART-driven bus initiator for the MIPS SoC data bus. It receives framed read and write commands as bytes from the UART receiver. It issues single-word transactions on the same read/write/addr/wdata/rdata/acc bus that the data memory and peripherals respond on, then returns read data and an ACK or NAK byte through the UART transmitter. It is used for host-side memory load, inspection and debug without CPU involvement, and sits beside the CPU as a second bus initiator; bus arbitration is external.

## Interface
Parameters:
- TIMEOUT_CYCLES, 1000000: maximum idle gap between bytes of one frame; exceeding it aborts the frame.
- CMD_RD, 8'h52: read command byte.
- CMD_WR, 8'h57: write command byte.
- RSP_ACK, 8'h06: success status byte.
- RSP_NAK, 8'h15: failure status byte.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; one clock, no other clock domains.
- rx_data  in  8  received byte, valid while rx_valid is high.
- rx_valid  in  1  receiver holds an unread byte.
- rx_read  out  1  one-cycle pulse that consumes the byte on rx_data.
- tx_data  out  8  byte to transmit; valid while tx_en is high.
- tx_en  out  1  one-cycle transmit strobe.
- tx_ready  in  1  transmitter idle; drops in the cycle after tx_en.
- bus_read  out  1  read strobe, exactly one cycle.
- bus_write  out  1  write strobe, exactly one cycle.
- bus_addr  out  32  transaction address, held from strobe until the next frame.
- bus_wdata  out  32  write data.
- bus_rdata  in  32  read data, combinational in the bus_read cycle.
- bus_read_acc  in  1  read accepted, same cycle as bus_read.
- bus_write_acc  in  1  write accepted, registered; sampled in the cycle after bus_write.
- busy  out  1  high in every state except IDLE.
- frame_err  out  1  one-cycle pulse on a bad command byte or a timeout.

## Operation
- Frame formats; multi-byte fields are big-endian:
  - Read: CMD_RD, A3..A0.
  - Write: CMD_WR, A3..A0, D3..D0.
- Responses:
  - Read: R3..R0 then the status byte. R is bus_rdata when acc is 1, otherwise 32'h0.
  - Write: status byte only.
- States: IDLE, GET_ADDR, GET_DATA, RX_GAP, BUS_RD, BUS_WR, WR_CHK, SEND.
- IDLE:
  - On rx_valid: pulse rx_read and latch the byte.
  - CMD_RD or CMD_WR goes to RX_GAP, then GET_ADDR.
  - Any other byte pulses frame_err, queues one RSP_NAK, and goes to SEND.
- RX_GAP: one-cycle guard after every rx_read. rx_valid is ignored, so one byte is never consumed twice.
- GET_ADDR / GET_DATA:
  - A 2-bit byte counter shifts bytes into bus_addr / bus_wdata.
  - After A0: go to BUS_RD for a read command, GET_DATA for a write command.
  - After D0: go to BUS_WR.
- BUS_RD:
  - bus_read=1 for one cycle.
  - Capture bus_read_acc and, when acc is 1, bus_rdata into the response register.
  - Go to SEND with 5 bytes queued.
- BUS_WR: bus_write=1 for one cycle, then WR_CHK.
- WR_CHK: sample bus_write_acc, queue ACK or NAK (1 byte), go to SEND.
- SEND:
  - Response is held in a 40-bit shift register with a byte count.
  - When tx_ready=1: pulse tx_en with the top byte, then wait one guard cycle.
  - Go to IDLE after the last byte.
- rx_valid during the bus states or SEND is left pending, not consumed. It is handled on return to IDLE.
- Timeout:
  - An inter-byte counter runs in GET_ADDR and GET_DATA and clears on each consumed byte.
  - On reaching TIMEOUT_CYCLES: pulse frame_err, send no response, no bus strobe, return to IDLE.
- No alignment check is made; a misaligned or unmapped address is reported through acc=0, giving NAK.

## Timing
- Reset values:
  - All outputs 0; bus_addr and bus_wdata 0.
  - State IDLE; counters and shift register cleared.
- Reset asserted mid-operation:
  - Aborts immediately; any strobe in progress drops asynchronously.
  - Partial frame and queued response are discarded.
- Cycle counts:
  - rx_read is asserted in the same cycle rx_valid is first seen in IDLE, GET_ADDR or GET_DATA. Minimum 2 cycles per received byte.
  - Last received byte to bus strobe: 1 cycle.
  - Read strobe to first tx_en: 1 cycle.
  - Write strobe to first tx_en: 2 cycles, when tx_ready=1.
  - tx_en pulses are at least 2 cycles apart.
- bus_read and bus_write are never high together, and never high for more than one cycle per frame.

## Structure
- Shared package holds:
  - The state enum.
  - CMD_RD, CMD_WR, RSP_ACK, RSP_NAK defaults.
  - Frame length constants: 4 address bytes, 4 data bytes, 5 read-response bytes.
- One sub-module, uart_bus_master_txq:
  - Function: 40-bit response shift register, byte count, and tx_ready/tx_en guard handshake.
  - Inputs: load strobe, data, length.
  - Output: done.

## Test plan
- Write:
  - Stimulus: bytes 57 00 00 00 10 DE AD BE EF, with bus_write_acc=1.
  - Required: one bus_write cycle with addr 0x10, wdata 0xDEADBEEF; tx sends 06; busy falls.
- Read:
  - Stimulus: 52 00 00 00 10; responder returns rdata 0xDEADBEEF, acc=1.
  - Required: one bus_read cycle; tx sends DE AD BE EF 06.
- Read of unmapped address:
  - Stimulus: 52 00 00 20 00, acc=0.
  - Required: tx sends 00 00 00 00 15.
- Bad command:
  - Stimulus: byte 41.
  - Required: frame_err pulses once; tx sends 15; no bus strobe; IDLE.
- Timeout (TIMEOUT_CYCLES=16):
  - Stimulus: 57 00 00, then 20 idle cycles.
  - Required: frame_err pulses; no tx_en, no bus strobe; a following valid read frame completes normally.
- Reset mid-SEND:
  - Stimulus: assert reset after 2 of 5 read-response bytes.
  - Required: tx_en, busy and bus strobes 0 immediately; the next write frame returns 06.

Source files
------------

// File: rtl/uart_bus_master_pkg.sv
// Shared types and constants for the UART-driven bus initiator.
package uart_bus_master_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_DATA,
        S_RX_GAP,
        S_BUS_RD,
        S_BUS_WR,
        S_WR_CHK,
        S_SEND
    } state_t;

    localparam logic [7:0] CMD_RD_DEF  = 8'h52;
    localparam logic [7:0] CMD_WR_DEF  = 8'h57;
    localparam logic [7:0] RSP_ACK_DEF = 8'h06;
    localparam logic [7:0] RSP_NAK_DEF = 8'h15;

    localparam int unsigned ADDR_BYTES   = 4;
    localparam int unsigned DATA_BYTES   = 4;
    localparam int unsigned RD_RSP_BYTES = 5;
    localparam int unsigned WR_RSP_BYTES = 1;

    localparam int unsigned RSP_W = 40;
    localparam int unsigned LEN_W = 3;

endpackage

// File: rtl/uart_bus_master_txq.sv
// Response byte queue: 40-bit shift register drained MSB-first into the UART transmitter.
module uart_bus_master_txq
    import uart_bus_master_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [RSP_W-1:0] data,
    input  logic [LEN_W-1:0] len,
    input  logic             tx_ready,
    output logic [7:0]       tx_data,
    output logic             tx_en,
    output logic             done
);

    logic [RSP_W-1:0] sr;
    logic [LEN_W-1:0] cnt;
    logic             guard;

    // A strobe needs queued bytes, an idle transmitter and a spent guard cycle.
    assign tx_en   = (cnt != '0) && !guard && tx_ready;
    assign tx_data = sr[RSP_W-1 -: 8];
    assign done    = (cnt == '0) && !guard;

    // Load, then shift one byte out per strobe with one guard cycle after each.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr    <= '0;
            cnt   <= '0;
            guard <= 1'b0;
        end else if (load) begin
            sr    <= data;
            cnt   <= len;
            guard <= 1'b0;
        end else begin
            guard <= tx_en;
            if (tx_en) begin
                sr  <= {sr[RSP_W-9:0], 8'h00};
                cnt <= cnt - LEN_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_bus_master.sv
// UART-framed single-word read/write initiator for the SoC data bus.
module uart_bus_master
    import uart_bus_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  CMD_RD         = CMD_RD_DEF,
    parameter logic [7:0]  CMD_WR         = CMD_WR_DEF,
    parameter logic [7:0]  RSP_ACK        = RSP_ACK_DEF,
    parameter logic [7:0]  RSP_NAK        = RSP_NAK_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_read,
    output logic [7:0]  tx_data,
    output logic        tx_en,
    input  logic        tx_ready,
    output logic        bus_read,
    output logic        bus_write,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_read_acc,
    input  logic        bus_write_acc,
    output logic        busy,
    output logic        frame_err
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t           state, state_d;
    logic [1:0]       byte_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             is_wr;
    logic             in_data;
    logic             frame_err_d;
    logic             load;
    logic [RSP_W-1:0] load_data;
    logic [LEN_W-1:0] load_len;
    logic             txq_done;
    logic             last_byte;
    logic             tmo_hit;

    assign last_byte = (byte_cnt == 2'(ADDR_BYTES - 1));
    assign tmo_hit   = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign bus_read  = (state == S_BUS_RD);
    assign bus_write = (state == S_BUS_WR);
    assign busy      = (state != S_IDLE);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_d;
    end

    // Next-state, byte consumption and response loading.
    always_comb begin
        state_d     = state;
        rx_read     = 1'b0;
        frame_err_d = 1'b0;
        load        = 1'b0;
        load_data   = '0;
        load_len    = '0;
        case (state)
            S_IDLE: begin
                if (rx_valid) begin
                    rx_read = 1'b1;
                    if (rx_data == CMD_RD || rx_data == CMD_WR) begin
                        state_d = S_RX_GAP;
                    end else begin
                        frame_err_d = 1'b1;
                        load        = 1'b1;
                        load_data   = {RSP_NAK, 32'h0};
                        load_len    = LEN_W'(WR_RSP_BYTES);
                        state_d     = S_SEND;
                    end
                end
            end
            S_RX_GAP: state_d = in_data ? S_GET_DATA : S_GET_ADDR;
            S_GET_ADDR, S_GET_DATA: begin
                if (rx_valid) begin
                    rx_read = 1'b1;
                    if (!last_byte)                state_d = S_RX_GAP;
                    else if (state == S_GET_DATA)  state_d = S_BUS_WR;
                    else if (is_wr)                state_d = S_RX_GAP;
                    else                           state_d = S_BUS_RD;
                end else if (tmo_hit) begin
                    frame_err_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_BUS_RD: begin
                load      = 1'b1;
                load_data = bus_read_acc ? {bus_rdata, RSP_ACK} : {32'h0, RSP_NAK};
                load_len  = LEN_W'(RD_RSP_BYTES);
                state_d   = S_SEND;
            end
            S_BUS_WR: state_d = S_WR_CHK;
            S_WR_CHK: begin
                load      = 1'b1;
                load_data = {(bus_write_acc ? RSP_ACK : RSP_NAK), 32'h0};
                load_len  = LEN_W'(WR_RSP_BYTES);
                state_d   = S_SEND;
            end
            S_SEND: if (txq_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Frame datapath: command type, address/data shift-in, byte counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_addr  <= '0;
            bus_wdata <= '0;
            byte_cnt  <= '0;
            is_wr     <= 1'b0;
            in_data   <= 1'b0;
        end else if (rx_read) begin
            case (state)
                S_IDLE: begin
                    is_wr    <= (rx_data == CMD_WR);
                    in_data  <= 1'b0;
                    byte_cnt <= '0;
                end
                S_GET_ADDR: begin
                    bus_addr <= {bus_addr[23:0], rx_data};
                    byte_cnt <= byte_cnt + 2'(1);
                    if (last_byte) in_data <= 1'b1;
                end
                S_GET_DATA: begin
                    bus_wdata <= {bus_wdata[23:0], rx_data};
                    byte_cnt  <= byte_cnt + 2'(1);
                end
                default: ;
            endcase
        end
    end

    // Inter-byte idle counter, live only while waiting for frame bytes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (rx_read || !(state == S_GET_ADDR || state == S_GET_DATA)) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    // Registered frame error pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) frame_err <= 1'b0;
        else       frame_err <= frame_err_d;
    end

    uart_bus_master_txq u_txq (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .data     (load_data),
        .len      (load_len),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_en    (tx_en),
        .done     (txq_done)
    );

endmodule

// File: tb/tb_uart_bus_master.sv
// Bench for uart_bus_master: table-driven frames plus directed corner cases.
module tb_uart_bus_master;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_read;
    logic [7:0]  tx_data;
    logic        tx_en;
    logic        tx_ready;
    logic        bus_read;
    logic        bus_write;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_read_acc;
    logic        bus_write_acc;
    logic        busy;
    logic        frame_err;

    always #5 clk = ~clk;

    uart_bus_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_read       (rx_read),
        .tx_data       (tx_data),
        .tx_en         (tx_en),
        .tx_ready      (tx_ready),
        .bus_read      (bus_read),
        .bus_write     (bus_write),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_rdata     (bus_rdata),
        .bus_read_acc  (bus_read_acc),
        .bus_write_acc (bus_write_acc),
        .busy          (busy),
        .frame_err     (frame_err)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Bus responder: combinational read, registered write accept.
    logic [31:0] resp_rdata = '0;
    logic        resp_acc   = 1'b0;
    assign bus_rdata    = resp_rdata;
    assign bus_read_acc = resp_acc;
    always @(posedge clk) bus_write_acc <= bus_write & resp_acc;

    // Transmitter model: busy for 3 cycles after each strobe.
    int tx_busy = 0;
    assign tx_ready = (tx_busy == 0);
    always @(posedge clk) begin
        if (tx_en)            tx_busy <= 3;
        else if (tx_busy > 0) tx_busy <= tx_busy - 1;
    end

    // Monitor and scoreboard.
    logic [7:0] exp_q[$];
    int cyc = 0, rd_cnt = 0, wr_cnt = 0, tx_cnt = 0, ferr_cnt = 0, overlap = 0;
    int strobe_cyc = 0, lat = -1;
    bit want_first = 0;
    logic [31:0] cap_addr, cap_wdata;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus_read && bus_write) overlap++;
        if (bus_read || bus_write) begin
            strobe_cyc = cyc;
            want_first = 1;
            cap_addr   = bus_addr;
            cap_wdata  = bus_wdata;
        end
        if (bus_read)  rd_cnt++;
        if (bus_write) wr_cnt++;
        if (frame_err) ferr_cnt++;
        if (tx_en) begin
            tx_cnt++;
            if (want_first) begin
                lat = cyc - strobe_cyc;
                want_first = 0;
            end
            n_checks++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL tx_unexpected: got %h required none", tx_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (tx_data !== e) begin
                    n_err++;
                    $display("FAIL tx_byte: got %h required %h", tx_data, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit got = 0;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (rx_read) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        if (!got) check("rx_read_timeout", 40'd0, 40'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = '0;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (!busy) begin
                ok = 1;
                break;
            end
        end
        check(name, 40'(ok), 40'd1);
    endtask

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        acc;
        logic [39:0] exp_rsp;
        int          exp_len;
    } vec_t;

    vec_t vecs[5];

    task automatic run_frame(input vec_t v);
        int rd0, wr0;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        lat = -1;
        resp_rdata = v.rdata;
        resp_acc   = v.acc;
        for (int i = 0; i < v.exp_len; i++) exp_q.push_back(v.exp_rsp[39-8*i -: 8]);
        send_byte(v.is_wr ? 8'h57 : 8'h52);
        for (int i = 0; i < 4; i++) send_byte(v.addr[31-8*i -: 8]);
        if (v.is_wr) for (int i = 0; i < 4; i++) send_byte(v.wdata[31-8*i -: 8]);
        wait_idle("busy_fall");
        check("rd_strobes", 40'(rd_cnt - rd0), 40'(!v.is_wr));
        check("wr_strobes", 40'(wr_cnt - wr0), 40'(v.is_wr));
        check("bus_addr", 40'(cap_addr), 40'(v.addr));
        if (v.is_wr) check("bus_wdata", 40'(cap_wdata), 40'(v.wdata));
        check("strobe_to_tx", 40'(lat), v.is_wr ? 40'd2 : 40'd1);
        check("rsp_drained", 40'(exp_q.size()), 40'd0);
    endtask

    initial begin
        int f0, t0, r0, w0;
        bit ok;
        vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b1, 40'h06_0000_0000, 1};
        vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b1, 40'hDE_AD_BE_EF_06, 5};
        vecs[2] = '{1'b0, 32'h0000_2000, 32'h0,         32'hCAFE_F00D, 1'b0, 40'h00_00_00_00_15, 5};
        vecs[3] = '{1'b1, 32'h0000_3003, 32'h1234_5678, 32'h0,         1'b0, 40'h15_0000_0000, 1};
        vecs[4] = '{1'b0, 32'h8000_0004, 32'h0,         32'h0102_A0FF, 1'b1, 40'h01_02_A0_FF_06, 5};

        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = '0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {31'd0, rx_read, tx_en, bus_read, bus_write, busy, frame_err, 3'd0}, 40'd0);
        check("rst_tx_data", 40'(tx_data), 40'd0);
        check("rst_addr", 40'(bus_addr), 40'd0);
        check("rst_wdata", 40'(bus_wdata), 40'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) run_frame(vecs[i]);

        // Bad command byte.
        f0 = ferr_cnt; r0 = rd_cnt; w0 = wr_cnt;
        exp_q.push_back(8'h15);
        send_byte(8'h41);
        wait_idle("badcmd_idle");
        check("badcmd_ferr", 40'(ferr_cnt - f0), 40'd1);
        check("badcmd_strobes", 40'((rd_cnt - r0) + (wr_cnt - w0)), 40'd0);
        check("badcmd_drained", 40'(exp_q.size()), 40'd0);

        // Inter-byte timeout mid-frame.
        f0 = ferr_cnt; r0 = rd_cnt; w0 = wr_cnt; t0 = tx_cnt;
        send_byte(8'h57);
        send_byte(8'h00);
        send_byte(8'h00);
        repeat (20) @(negedge clk);
        #1;
        check("tmo_ferr", 40'(ferr_cnt - f0), 40'd1);
        check("tmo_no_tx", 40'(tx_cnt - t0), 40'd0);
        check("tmo_strobes", 40'((rd_cnt - r0) + (wr_cnt - w0)), 40'd0);
        check("tmo_idle", 40'(busy), 40'd0);
        run_frame(vecs[1]);

        // Reset after two of five read-response bytes.
        t0 = tx_cnt;
        resp_rdata = 32'hA5A5_5A5A;
        resp_acc   = 1'b1;
        for (int i = 0; i < 5; i++) exp_q.push_back(8'(40'hA5_A5_5A_5A_06 >> (32 - 8*i)));
        send_byte(8'h52);
        for (int i = 0; i < 4; i++) send_byte(8'h00);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #2;
            if (tx_cnt - t0 >= 2) begin
                ok = 1;
                break;
            end
        end
        check("mid_send_reach", 40'(ok), 40'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_mid_outputs", {35'd0, tx_en, busy, bus_read, bus_write, 1'b0}, 40'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        run_frame(vecs[0]);

        check("no_overlap", 40'(overlap), 40'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

endmodule
